rr_slot_arbiter: RTL and testbench

- Round-robin time-slot arbiter that shares one resource (bus, ALU, output port) among N requesters.
- Rotation order follows the team's one-hot timing-ring convention: a one-hot priority pointer right-rotates from MSB toward bit 0, then wraps to the MSB.
- Each grant is bounded by a hold-time limit, so no requester can starve the others.
- Sits between requesting units and the shared datapath; its grant vector drives the resource's input select.

---
 rtl/rr_slot_arbiter.sv | 127 ++++++++++++
 tb/tb_rr_slot_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_slot_arbiter
// Purpose  : Round-robin time-slot arbiter with a one-hot rotating pointer and
//            a bounded hold time per grant.
// Revision : 1.0 - initial release
// ============================================================================
module rr_slot_arbiter #(
  parameter int N        = 8,
  parameter int ID_W     = 3,
  parameter int MAX_HOLD = 15,
  parameter int HOLD_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [N-1:0]    req,
  output logic [N-1:0]    gnt,
  output logic [ID_W-1:0] gnt_id,
  output logic            busy,
  output logic            timeout
);

  localparam logic [0:0]        c_IDLE     = 1'b0;
  localparam logic [0:0]        c_OWN      = 1'b1;
  localparam logic [HOLD_W-1:0] c_HOLD_MAX = HOLD_W'(MAX_HOLD);
  localparam logic [N-1:0]      c_PTR_RST  = {1'b1, {(N-1){1'b0}}};

  logic [0:0]        r_state, w_state_nxt;
  logic [N-1:0]      r_ptr, w_ptr_nxt;
  logic [HOLD_W-1:0] r_hold, w_hold_nxt;
  logic [N-1:0]      r_gnt, w_gnt_nxt;
  logic [ID_W-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic              r_timeout, w_timeout_nxt;

  logic [N-1:0]      w_mask, w_pick, w_win_oh;
  logic [ID_W-1:0]   w_win_id;
  logic              w_own_req, w_at_limit, w_start;

  // Bits 0..k (k = pointer position) are searched first, highest index wins;
  // the remaining bits above k form the wrap-around second pass.
  always_comb begin
    w_mask   = {r_ptr[N-2:0], 1'b0} - N'(1);
    w_pick   = ((req & w_mask) != '0) ? (req & w_mask) : (req & ~w_mask);
    w_win_id = '0;
    w_win_oh = '0;
    for (int i = 0; i < N; i++) begin
      if (w_pick[i]) begin
        w_win_id    = ID_W'(i);
        w_win_oh    = '0;
        w_win_oh[i] = 1'b1;
      end
    end
  end

  assign w_own_req  = req[r_gnt_id];
  assign w_at_limit = (r_hold == c_HOLD_MAX);
  assign w_start    = en && (req != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= c_IDLE;
      r_ptr     <= c_PTR_RST;
      r_hold    <= '0;
      r_gnt     <= '0;
      r_gnt_id  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_ptr     <= w_ptr_nxt;
      r_hold    <= w_hold_nxt;
      r_gnt     <= w_gnt_nxt;
      r_gnt_id  <= w_gnt_id_nxt;
      r_timeout <= w_timeout_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_IDLE:  if (w_start) w_state_nxt = c_OWN;
      c_OWN:   if (!w_own_req || w_at_limit) w_state_nxt = c_IDLE;
      default: w_state_nxt = c_IDLE;
    endcase
  end

  // A voluntary drop outranks the hold limit, so the pulse needs both conditions.
  always_comb begin
    w_ptr_nxt     = r_ptr;
    w_hold_nxt    = r_hold;
    w_gnt_nxt     = r_gnt;
    w_gnt_id_nxt  = r_gnt_id;
    w_timeout_nxt = 1'b0;
    case (r_state)
      c_IDLE: begin
        if (w_start) begin
          w_gnt_nxt    = w_win_oh;
          w_gnt_id_nxt = w_win_id;
          w_hold_nxt   = HOLD_W'(1);
        end
      end
      c_OWN: begin
        if (!w_own_req || w_at_limit) begin
          w_gnt_nxt     = '0;
          w_gnt_id_nxt  = '0;
          w_hold_nxt    = '0;
          w_ptr_nxt     = {r_gnt[0], r_gnt[N-1:1]};
          w_timeout_nxt = w_own_req;
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        w_gnt_nxt    = '0;
        w_gnt_id_nxt = '0;
        w_hold_nxt   = '0;
      end
    endcase
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign busy    = (r_state == c_OWN);
  assign timeout = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_rr_slot_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_slot_arbiter
// Purpose  : Scoreboard bench for rr_slot_arbiter against an index-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_slot_arbiter;

  localparam int N        = 8;
  localparam int ID_W     = 3;
  localparam int MAX_HOLD = 15;
  localparam int HOLD_W   = 4;

  typedef struct packed {
    logic [N-1:0]    gnt;
    logic [ID_W-1:0] id;
    logic            busy;
    logic            to;
  } obs_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en  = 1'b0;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    gnt;
  logic [ID_W-1:0] gnt_id;
  logic            busy;
  logic            timeout;

  int total = 0;
  int bad   = 0;

  obs_t exp_q[$];

  // Reference model state: owner index (-1 = none), pointer index, hold count
  int m_owner = -1;
  int m_ptr   = N - 1;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  rr_slot_arbiter #(.N(N), .ID_W(ID_W), .MAX_HOLD(MAX_HOLD), .HOLD_W(HOLD_W)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic obs_t model_obs();
    obs_t o;
    o.gnt  = (m_owner < 0) ? '0 : N'(1) << m_owner;
    o.id   = (m_owner < 0) ? '0 : ID_W'(m_owner);
    o.busy = (m_owner >= 0);
    o.to   = m_to;
    return o;
  endfunction

  function automatic void model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_hold  = 0;
    m_to    = 1'b0;
  endfunction

  function automatic void model_step(input logic e, input logic [N-1:0] r);
    m_to = 1'b0;
    if (m_owner < 0) begin
      if (e && r != '0) begin
        for (int s = 0; s < N; s++) begin
          int idx;
          idx = (m_ptr - s + N) % N;
          if (r[idx] && m_owner < 0) begin
            m_owner = idx;
            m_hold  = 1;
          end
        end
      end
    end else if (!r[m_owner] || m_hold == MAX_HOLD) begin
      m_to    = r[m_owner];
      m_ptr   = (m_owner - 1 + N) % N;
      m_owner = -1;
      m_hold  = 0;
    end else begin
      m_hold = m_hold + 1;
    end
  endfunction

  task automatic cycle(input logic e, input logic [N-1:0] r);
    @(negedge clk);
    en  = e;
    req = r;
    model_step(e, r);
    exp_q.push_back(model_obs());
  endtask

  task automatic check_now(input string name);
    obs_t act, expv;
    act  = '{gnt, gnt_id, busy, timeout};
    expv = model_obs();
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got gnt=%h id=%0d busy=%b to=%b, want gnt=%h id=%0d busy=%b to=%b",
               name, act.gnt, act.id, act.busy, act.to, expv.gnt, expv.id, expv.busy, expv.to);
    end
  endtask

  // Asynchronous reset asserted mid-cycle, well away from either clock edge
  task automatic pulse_reset();
    @(negedge clk);
    #2;
    rst = 1'b0;
    en  = 1'b0;
    req = '0;
    model_reset();
    #1;
    check_now("async_reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  // Monitor: compares every popped expectation one step after the edge
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        obs_t e;
        obs_t a;
        e = exp_q.pop_front();
        a = '{gnt, gnt_id, busy, timeout};
        total++;
        if (a !== e) begin
          bad++;
          $display("FAIL cycle@%0t: got gnt=%h id=%0d busy=%b to=%b, want gnt=%h id=%0d busy=%b to=%b",
                   $time, a.gnt, a.id, a.busy, a.to, e.gnt, e.id, e.busy, e.to);
        end
      end
    end
  end

  initial begin
    logic [N-1:0] r;
    int guard;

    // Power-on reset pulse at t = 2 ns
    #2;
    rst = 1'b0;
    model_reset();
    #1;
    check_now("power_on_reset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    repeat (10) cycle(1'b1, '0);

    // Single requester on bit 0, then drop
    repeat (5) cycle(1'b1, 8'h01);
    repeat (3) cycle(1'b1, '0);

    // Everyone requesting: full rotation through all timeouts
    repeat (9 * (MAX_HOLD + 1) + 2) cycle(1'b1, 8'hFF);
    repeat (2) cycle(1'b1, '0);

    // Sparse rotation from a reset pointer
    pulse_reset();
    cycle(1'b1, 8'h24);
    repeat (3) cycle(1'b1, 8'h24);
    cycle(1'b1, 8'h04);
    repeat (4) cycle(1'b1, 8'h24);
    repeat (2) cycle(1'b1, 8'h20);
    repeat (2) cycle(1'b1, '0);

    // Enable gating: no new grant while en is low, owner survives en dropping
    repeat (4) cycle(1'b0, 8'h10);
    cycle(1'b1, 8'h10);
    repeat (5) cycle(1'b0, 8'h10);
    repeat (MAX_HOLD) cycle(1'b0, 8'h10);
    repeat (2) cycle(1'b0, '0);

    // Reset during an active grant, then verify pointer restart at bit 7
    repeat (4) cycle(1'b1, 8'h06);
    pulse_reset();
    repeat (3) cycle(1'b1, 8'h81);
    repeat (2) cycle(1'b1, '0);

    // Owner drops its request exactly on the limit edge: no timeout pulse
    guard = 0;
    cycle(1'b1, 8'h18);
    while (!(m_owner >= 0 && m_hold == MAX_HOLD) && guard < 100) begin
      cycle(1'b1, 8'h18);
      guard++;
    end
    total++;
    if (guard >= 100) begin
      bad++;
      $display("FAIL limit_reach: got guard=%0d, want <100", guard);
    end
    r = 8'h18;
    r[m_owner] = 1'b0;
    cycle(1'b1, r);
    repeat (2) cycle(1'b1, '0);

    // Randomized traffic with slowly toggling request bits
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      for (int b = 0; b < N; b++)
        if ($urandom_range(0, 11) == 0) r[b] = ~r[b];
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset();
      end
      cycle(($urandom_range(0, 4) != 0), r);
    end

    repeat (3) @(negedge clk);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending, want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
